// File: rtl/lsu_dmem_pkg.sv
// Shared encodings for the load/store unit: dmem_mask fields and FSM states.
package lsu_dmem_pkg;

    // dmem_mask[1:0] access size
    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_BYTE = 2'b10;

    // dmem_mask bit that selects sign extension on loads
    localparam int unsigned MASK_SEXT = 2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_dmem_align.sv
// Lane logic for the LSU: byte enables, write-data replication,
// read-data alignment/extension and misalignment detection.
module lsu_align
    import lsu_dmem_pkg::*;
(
    input  logic [2:0]  mask_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;
    logic        sext;

    assign sext    = mask_i[MASK_SEXT];
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    // Decode access size into lanes, replicated store data and extended load data.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (mask_i[1:0])
            MASK_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{sext & shifted[15]}}, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            MASK_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            default: begin
                // Word (and the unused 2'b11 code) passes through unchanged.
                misalign_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit: turns a decoded load/store into a req/gnt/rvalid
// transaction on the data-memory bus and stalls the core until it finishes.
module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [2:0]  mask_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_e  state_q, state_d;

    logic [1:0]  addr_lo_q;
    logic [2:0]  mask_q;
    logic        we_q;
    logic        err_q;
    logic        misalign_q;
    logic [31:0] rdata_q;
    logic [31:0] cnt_q;

    logic        bus_req_q;
    logic        bus_we_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;

    logic        idle;
    logic        accept;
    logic        timeout_hit;
    logic [2:0]  al_mask;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;

    assign idle   = (state_q == LSU_IDLE);
    assign accept = idle && (load_i || store_i);

    // The counter value on the last allowed REQ/WAIT cycle is TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0)
                      && ((state_q == LSU_REQ) || (state_q == LSU_WAIT))
                      && (cnt_q == 32'(TIMEOUT - 1));

    // In IDLE the lane logic sees the live instruction (lanes for the request);
    // afterwards it sees the captured mask/offset (extension of the response).
    assign al_mask    = idle ? mask_i      : mask_q;
    assign al_addr_lo = idle ? addr_i[1:0] : addr_lo_q;

    lsu_align u_align (
        .mask_i     (al_mask),
        .addr_lo_i  (al_addr_lo),
        .wdata_i    (wdata_i),
        .rdata_i    (rdata_q),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic; a timeout overrides a same-cycle grant or response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_IDLE: if (accept) state_d = al_misalign ? LSU_DONE : LSU_REQ;
            LSU_REQ: begin
                if (timeout_hit)    state_d = LSU_DONE;
                else if (bus_gnt_i) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (timeout_hit)       state_d = LSU_DONE;
                else if (bus_rvalid_i) state_d = LSU_DONE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Core-facing outputs; result fields read zero outside DONE.
    always_comb begin
        stall_o    = accept || (state_q == LSU_REQ) || (state_q == LSU_WAIT);
        done_o     = (state_q == LSU_DONE);
        err_o      = done_o && err_q;
        misalign_o = done_o && misalign_q;
        rdata_o    = (done_o && !we_q && !err_q && !misalign_q) ? al_rdata : 32'h0;
    end

    // Transaction registers, timeout counter and registered bus outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: all control and data registers are reset so a mid-transaction reset drops everything.
            addr_lo_q   <= 2'b00;
            mask_q      <= 3'b000;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_q     <= 32'h0;
            cnt_q       <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
        end else begin
            if (idle) begin
                cnt_q <= 32'h0;
            end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
                cnt_q <= cnt_q + 32'd1;
            end

            if (accept) begin
                addr_lo_q  <= addr_i[1:0];
                mask_q     <= mask_i;
                we_q       <= store_i;
                err_q      <= 1'b0;
                misalign_q <= al_misalign;
                rdata_q    <= 32'h0;
            end else if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end else if ((state_q == LSU_WAIT) && bus_rvalid_i) begin
                rdata_q <= bus_rdata_i;
            end

            bus_req_q <= (state_d == LSU_REQ);

            if (accept && !al_misalign) begin
                bus_we_q    <= store_i;
                bus_be_q    <= al_be;
                bus_addr_q  <= {addr_i[31:2], 2'b00};
                bus_wdata_q <= al_wdata;
            end else if (state_d == LSU_DONE) begin
                bus_we_q    <= 1'b0;
                bus_be_q    <= 4'b0000;
                bus_addr_q  <= 32'h0;
                bus_wdata_q <= 32'h0;
            end
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_be_o    = bus_be_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: loads/stores of each size, misalignment,
// timeout abort and reset in the middle of a transaction.
module tb_lsu_dmem;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT (generous timeout)
    logic        load, store, gnt, rvalid;
    logic [2:0]  mask;
    logic [31:0] addr, wdata, rdata_in;
    logic        stall_o, done_o, misalign_o, err_o, bus_req_o, bus_we_o;
    logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;

    // Second DUT with a short timeout and a bus that never grants
    logic        load_b, rvalid_b;
    logic        stall_b, done_b, misalign_b, err_b, bus_req_b, bus_we_b;
    logic [31:0] rdata_b, bus_addr_b, bus_wdata_b;
    logic [3:0]  bus_be_b;

    int errors = 0;
    int checks = 0;

    lsu_dmem #(.TIMEOUT(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .store_i(store), .mask_i(mask),
        .addr_i(addr), .wdata_i(wdata), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .misalign_o(misalign_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(gnt),
        .bus_rvalid_i(rvalid), .bus_rdata_i(rdata_in)
    );

    lsu_dmem #(.TIMEOUT(4)) u_dut_to (
        .clk_i(clk), .rst_i(rst), .load_i(load_b), .store_i(1'b0), .mask_i(3'b000),
        .addr_i(32'h0000_0040), .wdata_i(32'h0), .stall_o(stall_b), .done_o(done_b),
        .rdata_o(rdata_b), .misalign_o(misalign_b), .err_o(err_b),
        .bus_req_o(bus_req_b), .bus_we_o(bus_we_b), .bus_be_o(bus_be_b),
        .bus_addr_o(bus_addr_b), .bus_wdata_o(bus_wdata_b), .bus_gnt_i(1'b0),
        .bus_rvalid_i(rvalid_b), .bus_rdata_i(32'hFFFF_FFFF)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Runs one access on the main DUT. Called just after a rising edge.
    // gnt_dly: extra REQ cycles before grant; rv_dly: extra WAIT cycles before rvalid.
    task automatic access(
        input  logic        ld, st,
        input  logic [2:0]  m,
        input  logic [31:0] a, wd,
        input  int          gnt_dly, rv_dly,
        input  logic [31:0] rd,
        output int          stalls, reqs, total,
        output logic        seen,
        output logic [3:0]  be,
        output logic [31:0] baddr, bwdata,
        output logic        bwe,
        output logic [31:0] rdat,
        output logic        mis, err
    );
        logic granted;
        int   req_seen, wait_seen;
        granted = 1'b0; req_seen = 0; wait_seen = 0;
        stalls = 0; reqs = 0; total = 0; seen = 1'b0;
        be = '0; baddr = '0; bwdata = '0; bwe = 1'b0; rdat = '0; mis = 1'b0; err = 1'b0;
        load = ld; store = st; mask = m; addr = a; wdata = wd;
        for (int c = 0; c < 40 && !seen; c++) begin
            gnt = 1'b0; rvalid = 1'b0; rdata_in = 32'h0;
            if (bus_req_o) begin
                if (req_seen >= gnt_dly) gnt = 1'b1;
                req_seen++;
            end else if (granted) begin
                if (wait_seen >= rv_dly) begin
                    rvalid = 1'b1; rdata_in = rd;
                end
                wait_seen++;
            end
            #1;
            if (stall_o) stalls++;
            if (bus_req_o) begin
                reqs++;
                be = bus_be_o; baddr = bus_addr_o; bwdata = bus_wdata_o; bwe = bus_we_o;
            end
            if (done_o) begin
                seen = 1'b1; total = c + 1;
                rdat = rdata_o; mis = misalign_o; err = err_o;
                load = 1'b0; store = 1'b0;
            end
            if (gnt) granted = 1'b1;
            @(posedge clk); #1;
        end
        gnt = 1'b0; rvalid = 1'b0; rdata_in = 32'h0;
        load = 1'b0; store = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          stalls, reqs, total, to_reqs, to_cycles;
        logic        seen, bwe, mis, err, to_err, to_req_at_done;
        logic [3:0]  be;
        logic [31:0] baddr, bwdata, rdat, to_rdata;

        rst = 1'b1;
        load = 0; store = 0; mask = 0; addr = 0; wdata = 0;
        gnt = 0; rvalid = 0; rdata_in = 0; load_b = 0; rvalid_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done",  32'(done_o),    32'd0);
        check("rst_req",   32'(bus_req_o), 32'd0);
        check("rst_rdata", rdata_o,        32'h0);
        check("rst_be",    32'(bus_be_o),  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_stall", 32'(stall_o), 32'd0);

        // LW 0x100, grant with request, response next cycle
        access(1, 0, 3'b000, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("lw_done",   32'(seen),  32'd1);
        check("lw_be",     32'(be),    32'hF);
        check("lw_addr",   baddr,      32'h100);
        check("lw_we",     32'(bwe),   32'd0);
        check("lw_rdata",  rdat,       32'hDEADBEEF);
        check("lw_stalls", stalls,     32'd3);
        check("lw_cycles", total,      32'd4);
        #1;
        check("lw_after_done",  32'(done_o), 32'd0);
        check("lw_after_rdata", rdata_o,     32'h0);

        // LB 0x103 signed, then LBU
        access(1, 0, 3'b110, 32'h103, 32'h0, 0, 0, 32'h80112233,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("lb_be",    32'(be), 32'h8);
        check("lb_addr",  baddr,   32'h100);
        check("lb_rdata", rdat,    32'hFFFFFF80);
        access(1, 0, 3'b010, 32'h103, 32'h0, 0, 0, 32'h80112233,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("lbu_rdata", rdat, 32'h00000080);

        // LH upper half signed, LHU lower half
        access(1, 0, 3'b101, 32'h002, 32'h0, 0, 1, 32'h80011234,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("lh_be",     32'(be), 32'hC);
        check("lh_rdata",  rdat,    32'hFFFF8001);
        check("lh_cycles", total,   32'd5);
        access(1, 0, 3'b001, 32'h000, 32'h0, 0, 0, 32'h1234F00D,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("lhu_be",    32'(be), 32'h3);
        check("lhu_rdata", rdat,    32'h0000F00D);

        // SH 0x202, grant delayed 3 cycles
        access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 3, 0, 32'hFFFFFFFF,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("sh_done",  32'(seen), 32'd1);
        check("sh_be",    32'(be),   32'hC);
        check("sh_wdata", bwdata,    32'hABCDABCD);
        check("sh_we",    32'(bwe),  32'd1);
        check("sh_addr",  baddr,     32'h200);
        check("sh_reqs",  reqs,      32'd4);
        check("sh_rdata", rdat,      32'h0);

        // SB 0x001
        access(0, 1, 3'b010, 32'h001, 32'h0000005A, 0, 0, 32'h0,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("sb_be",    32'(be), 32'h2);
        check("sb_wdata", bwdata,  32'h5A5A5A5A);

        // Misaligned LW 0x101 and LH 0x003
        access(1, 0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h12345678,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("mis_lw_reqs",   reqs,     32'd0);
        check("mis_lw_flag",   32'(mis), 32'd1);
        check("mis_lw_cycles", total,    32'd2);
        check("mis_lw_rdata",  rdat,     32'h0);
        access(1, 0, 3'b001, 32'h003, 32'h0, 0, 0, 32'h0,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("mis_lh_flag", 32'(mis), 32'd1);
        check("mis_lh_reqs", reqs,     32'd0);

        // Timeout on the second instance: grant never comes
        to_reqs = 0; to_cycles = 0; to_err = 0; to_rdata = 32'hDEAD; to_req_at_done = 1;
        load_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus_req_b) to_reqs++;
            if (done_b) begin
                to_cycles = c + 1; to_err = err_b; to_rdata = rdata_b;
                to_req_at_done = bus_req_b; load_b = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        load_b = 1'b0;
        check("to_reqs",      to_reqs,               32'd4);
        check("to_cycles",    to_cycles,             32'd6);
        check("to_err",       32'(to_err),           32'd1);
        check("to_rdata",     to_rdata,              32'h0);
        check("to_req_drop",  32'(to_req_at_done),   32'd0);
        @(posedge clk); #1;
        rvalid_b = 1'b1;
        #1;
        check("to_late_done",  32'(done_b),  32'd0);
        check("to_late_stall", 32'(stall_b), 32'd0);
        @(posedge clk); #1;
        rvalid_b = 1'b0;
        #1;
        check("to_late_done2", 32'(done_b), 32'd0);

        // Reset while in WAIT, then a stray response
        load = 1'b1; mask = 3'b000; addr = 32'h300;
        @(posedge clk); #1;          // now REQ
        gnt = 1'b1;
        @(posedge clk); #1;          // now WAIT
        gnt = 1'b0; load = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_req",   32'(bus_req_o), 32'd0);
        check("mid_rst_stall", 32'(stall_o),   32'd0);
        check("mid_rst_addr",  bus_addr_o,     32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rvalid = 1'b1; rdata_in = 32'h12345678;
        #1;
        check("post_rst_done",  32'(done_o),  32'd0);
        check("post_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata_in = 32'h0;
        #1;
        check("post_rst_done2", 32'(done_o), 32'd0);
        check("post_rst_rdata", rdata_o,     32'h0);

        access(1, 0, 3'b000, 32'h104, 32'h0, 1, 0, 32'hCAFEF00D,
               stalls, reqs, total, seen, be, baddr, bwdata, bwe, rdat, mis, err);
        check("rec_lw_done",  32'(seen), 32'd1);
        check("rec_lw_addr",  baddr,     32'h104);
        check("rec_lw_rdata", rdat,      32'hCAFEF00D);
        check("rec_lw_err",   32'(err),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
